// File: rtl/gpp_stack_engine.sv
// gpp_stack_engine -- LIFO stack with a request/response handshake.
//
// Each accepted request gets exactly one response, one cycle later. The
// response is held until the consumer takes it. Throughput is one op per
// cycle while rsp_ready stays high.
//
// Optional feature macro: GPP_STACK_HWM_EN
//   When defined, adds the hwm output and its high-water-mark register.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  request can be accepted (combinational)
//   req_op     00 PUSH, 01 POP, 10 PEEK, 11 CLEAR
//   req_data   PUSH operand
//   rsp_valid  response present
//   rsp_ready  consumer takes the response
//   rsp_data   POP/PEEK result, zero otherwise
//   rsp_err    request failed (PUSH on full, POP/PEEK on empty)
//   count      occupied entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky PUSH-on-full flag
//   underflow  sticky POP/PEEK-on-empty flag
//   err_clr    clears the sticky flags (and hwm when present)
//   hwm        high-water mark (GPP_STACK_HWM_EN only)
module gpp_stack_engine #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [DATA_W-1:0]             req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_err,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          err_clr
`ifdef GPP_STACK_HWM_EN
  ,output logic [$clog2(DEPTH):0]       hwm
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  count_q, count_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              ovf_set, unf_set;
  logic              wr_en;
  logic              accept;
  logic [ADDR_W-1:0] wr_idx, top_idx;
  logic [CNT_W-1:0]  count_m1;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;

  // count is DEPTH only when full, and no write happens then, so the low
  // ADDR_W bits are always a valid write index when used.
  assign wr_idx   = count_q[ADDR_W-1:0];
  assign count_m1 = count_q - 1'b1;
  assign top_idx  = count_m1[ADDR_W-1:0];

  always_comb begin
    count_d     = count_q;
    // A taken response retires unless replaced by a new one below.
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    wr_en       = 1'b0;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = '0;
      rsp_err_d   = 1'b0;
      case (req_op)
        OP_PUSH: begin
          if (full) begin
            ovf_set   = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        OP_POP, OP_PEEK: begin
          if (empty) begin
            unf_set   = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            rsp_data_d = mem[top_idx];
            if (req_op == OP_POP) count_d = count_m1;
          end
        end
        OP_CLEAR: count_d = '0;
        default: ;
      endcase
    end
    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = (ovf_q && !err_clr) || ovf_set;
    unf_d = (unf_q && !err_clr) || unf_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= req_data;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef GPP_STACK_HWM_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;

  // Tracks the next count so a same-cycle increase lands immediately,
  // including the cycle err_clr wipes the old mark.
  always_comb begin
    hwm_d = err_clr ? '0 : hwm_q;
    if (count_d > hwm_d) hwm_d = count_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_gpp_stack_engine.sv
// Directed bench for gpp_stack_engine at DATA_W=16, DEPTH=4.
module tb_gpp_stack_engine;
  localparam int DW = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [2:0]    count;
  logic          full, empty, overflow, underflow, err_clr;
`ifdef GPP_STACK_HWM_EN
  logic [2:0]    hwm;
`endif

  int errs   = 0;
  int checks = 0;

  gpp_stack_engine #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
`ifdef GPP_STACK_HWM_EN
    , .hwm(hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request, accepted on the next rising edge; response sampled 1ns later.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = '0;
    rsp_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_flags", {30'b0, overflow, underflow}, 0);
`ifdef GPP_STACK_HWM_EN
    chk("rst_hwm", 32'(hwm), 0);
`endif
    @(negedge clk); rst = 1'b0;

    // Basic LIFO order
    issue(2'b00, 16'h1111);
    chk("push1_valid", 32'(rsp_valid), 1);
    chk("push1_rsp", {15'b0, rsp_err, rsp_data}, 0);
    chk("push1_count", 32'(count), 1);
    issue(2'b00, 16'h2222);
    chk("push2_count", 32'(count), 2);
    issue(2'b01, 16'h0);
    chk("pop1_data", 32'(rsp_data), 32'h2222);
    chk("pop1_count", 32'(count), 1);
    issue(2'b01, 16'h0);
    chk("pop2_data", 32'(rsp_data), 32'h1111);
    chk("pop2_err", 32'(rsp_err), 0);
    chk("pop2_empty", 32'(empty), 1);
    chk("pop2_count", 32'(count), 0);

    // Overflow at DEPTH
    for (int i = 0; i < 4; i++) issue(2'b00, 16'(16'hA0 + i));
    chk("fill_count", 32'(count), 4);
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf", 32'(overflow), 0);
    issue(2'b00, 16'hA4);
    chk("push5_err", 32'(rsp_err), 1);
    chk("push5_data", 32'(rsp_data), 0);
    chk("push5_ovf", 32'(overflow), 1);
    chk("push5_count", 32'(count), 4);
    // New overflow in the same cycle as err_clr keeps the flag set
    @(negedge clk); err_clr = 1'b1;
    issue(2'b00, 16'hA5);
    err_clr = 1'b0;
    chk("ovf_wins_clr", 32'(overflow), 1);
    issue(2'b01, 16'h0);
    chk("pop_after_full", 32'(rsp_data), 32'hA3);
    chk("pop_after_full_cnt", 32'(count), 3);
`ifdef GPP_STACK_HWM_EN
    chk("hwm_full", 32'(hwm), 4);
`endif
    clr_pulse();
    chk("ovf_cleared", 32'(overflow), 0);
    issue(2'b11, 16'h0);
    chk("clear_count", 32'(count), 0);

    // Underflow
    issue(2'b01, 16'h0);
    chk("unf_err", 32'(rsp_err), 1);
    chk("unf_data", 32'(rsp_data), 0);
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_count", 32'(count), 0);
    clr_pulse();
    chk("unf_cleared", 32'(underflow), 0);

    // Backpressure: response held, second request stalls
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_op = 2'b00; req_data = 16'h5A5A;
    @(posedge clk); #1;
    req_data = 16'h6666;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_count", 32'(count), 1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_second_count", 32'(count), 2);
    chk("bp_second_valid", 32'(rsp_valid), 1);
    issue(2'b01, 16'h0);
    chk("bp_pop1", 32'(rsp_data), 32'h6666);
    issue(2'b01, 16'h0);
    chk("bp_pop2", 32'(rsp_data), 32'h5A5A);

    // PEEK / CLEAR
    issue(2'b00, 16'h0001);
    issue(2'b10, 16'h0);
    chk("peek_data", 32'(rsp_data), 32'h0001);
    chk("peek_err", 32'(rsp_err), 0);
    chk("peek_count", 32'(count), 1);
    issue(2'b11, 16'h0);
    chk("clear2_count", 32'(count), 0);
    chk("clear2_empty", 32'(empty), 1);
    issue(2'b10, 16'h0);
    chk("peek_empty_err", 32'(rsp_err), 1);
    chk("peek_empty_data", 32'(rsp_data), 0);
    clr_pulse();

    // Reset during a pending response
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_op = 2'b00; req_data = 16'h7777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst_valid", 32'(rsp_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 0);
    chk("async_rst_count", 32'(count), 0);
`ifdef GPP_STACK_HWM_EN
    chk("async_rst_hwm", 32'(hwm), 0);
`endif
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_discarded", 32'(rsp_valid), 0);
`ifdef GPP_STACK_HWM_EN
    for (int i = 0; i < 3; i++) issue(2'b00, 16'(i));
    issue(2'b01, 16'h0);
    chk("hwm_3", 32'(hwm), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
